// File: rtl/pong_draw_scheduler_if.sv
// rtl/pong_draw_scheduler_if.sv - requester and VGA adapter signal bundle for the pong draw scheduler
//
// Purpose: groups the per-requester rectangle requests, the grant/done
// handshake and the pixel-write port of the VGA adapter.
// Modports:
//   master - requester/adapter side: drives req and rectangle fields,
//            observes grant, done, busy and the pixel port.
//   slave  - scheduler side: the reverse.
// Signals:
//   req        NUM_REQ    level draw request per requester
//   req_x      8*NUM_REQ  rectangle left x, requester i at [8i+7:8i]
//   req_y      7*NUM_REQ  rectangle top y, requester i at [7i+6:7i]
//   req_w      8*NUM_REQ  rectangle width
//   req_h      7*NUM_REQ  rectangle height
//   req_colour 3*NUM_REQ  fill colour
//   grant      NUM_REQ    one-hot, high for the whole job
//   done       NUM_REQ    one-cycle completion pulse
//   busy       1          scheduler not idle
//   x, y       8, 7       pixel coordinate to the adapter
//   colour     3          pixel colour to the adapter
//   plot       1          pixel write enable to the adapter

interface pong_draw_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_x;
    logic [7*NUM_REQ-1:0] req_y;
    logic [8*NUM_REQ-1:0] req_w;
    logic [7*NUM_REQ-1:0] req_h;
    logic [3*NUM_REQ-1:0] req_colour;
    logic [NUM_REQ-1:0]   grant;
    logic [NUM_REQ-1:0]   done;
    logic                 busy;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [2:0]           colour;
    logic                 plot;

    modport master (
        output req, req_x, req_y, req_w, req_h, req_colour,
        input  grant, done, busy, x, y, colour, plot
    );

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_colour,
        output grant, done, busy, x, y, colour, plot
    );
endinterface

// File: rtl/pong_draw_scheduler.sv
// rtl/pong_draw_scheduler.sv - arbitrated filled-rectangle drawer for a 160x120 3-bit VGA adapter
//
// Purpose: shares the adapter's single pixel-write port among NUM_REQ
// rectangle requesters (clear, paddles, ball). One requester is granted at
// a time; its rectangle is latched and scanned one pixel per clock, x inner
// and y outer, with off-screen pixels clipped (plot low, cycle still spent).
// Ports:
//   clock - system clock
//   reset - asynchronous, active-high reset; aborts any job in progress
//   bus   - pong_draw_scheduler_if.slave: requests, grant/done/busy and
//           the adapter's x/y/colour/plot inputs (all outputs registered)
// Configuration:
//   ROUND_ROBIN_EN - when defined, arbitration is round-robin starting after
//                    the last granted index; otherwise lowest index wins.

module pong_draw_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic                  clock,
    input  logic                  reset,
    pong_draw_scheduler_if.slave  bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [8:0] SW = 9'(SCREEN_W);
    localparam logic [7:0] SH = 8'(SCREEN_H);

    typedef enum logic [1:0] {IDLE, LATCH, DRAW, DONE} state_t;

    state_t               state, state_n;
    logic [NUM_REQ-1:0]   grant_r, grant_n;
    logic [NUM_REQ-1:0]   done_r, done_n;
    logic                 busy_r, busy_n;
    logic [7:0]           x_r, x_n;
    logic [6:0]           y_r, y_n;
    logic [2:0]           colour_r, colour_n;
    logic                 plot_r, plot_n;

    // Job fields captured at the grant edge so later request changes are ignored.
    logic [7:0]           x0_r, x0_n;
    logic [6:0]           y0_r, y0_n;
    logic [7:0]           w_r, w_n;
    logic [6:0]           h_r, h_n;
    logic [2:0]           col_r, col_n;

    // Scan counters hold the pixel currently on the output registers.
    logic [7:0]           cx_r, cx_n;
    logic [6:0]           cy_r, cy_n;

    logic [IW-1:0]        win;
    logic                 pix_valid;
    logic [8:0]           sum_x;
    logic [7:0]           sum_y;

`ifdef ROUND_ROBIN_EN
    logic [IW-1:0]        ptr_r, ptr_n;
    logic                 found;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_r  <= '0;
            done_r   <= '0;
            busy_r   <= 1'b0;
            x_r      <= '0;
            y_r      <= '0;
            colour_r <= '0;
            plot_r   <= 1'b0;
            x0_r     <= '0;
            y0_r     <= '0;
            w_r      <= '0;
            h_r      <= '0;
            col_r    <= '0;
            cx_r     <= '0;
            cy_r     <= '0;
`ifdef ROUND_ROBIN_EN
            ptr_r    <= '0;
`endif
        end else begin
            state    <= state_n;
            grant_r  <= grant_n;
            done_r   <= done_n;
            busy_r   <= busy_n;
            x_r      <= x_n;
            y_r      <= y_n;
            colour_r <= colour_n;
            plot_r   <= plot_n;
            x0_r     <= x0_n;
            y0_r     <= y0_n;
            w_r      <= w_n;
            h_r      <= h_n;
            col_r    <= col_n;
            cx_r     <= cx_n;
            cy_r     <= cy_n;
`ifdef ROUND_ROBIN_EN
            ptr_r    <= ptr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        grant_n   = grant_r;
        done_n    = '0;
        x_n       = x_r;
        y_n       = y_r;
        colour_n  = colour_r;
        plot_n    = 1'b0;
        x0_n      = x0_r;
        y0_n      = y0_r;
        w_n       = w_r;
        h_n       = h_r;
        col_n     = col_r;
        cx_n      = cx_r;
        cy_n      = cy_r;
        pix_valid = 1'b0;
        win       = '0;

`ifdef ROUND_ROBIN_EN
        ptr_n = ptr_r;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && bus.req[(int'(ptr_r) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(ptr_r) + k) % NUM_REQ);
            end
        end
`else
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[i]) begin
                win = IW'(i);
            end
        end
`endif

        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_n = LATCH;
                    grant_n = {{(NUM_REQ-1){1'b0}}, 1'b1} << win;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win == IW'(i)) begin
                            x0_n  = bus.req_x[8*i +: 8];
                            y0_n  = bus.req_y[7*i +: 7];
                            w_n   = bus.req_w[8*i +: 8];
                            h_n   = bus.req_h[7*i +: 7];
                            col_n = bus.req_colour[3*i +: 3];
                        end
                    end
`ifdef ROUND_ROBIN_EN
                    ptr_n = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
`endif
                end
            end
            LATCH: begin
                cx_n = '0;
                cy_n = '0;
                if (w_r != 8'd0 && h_r != 7'd0) begin
                    state_n   = DRAW;
                    pix_valid = 1'b1;
                end else begin
                    state_n = DONE;
                    done_n  = grant_r;
                end
            end
            DRAW: begin
                if (cx_r == w_r - 8'd1 && cy_r == h_r - 7'd1) begin
                    state_n = DONE;
                    done_n  = grant_r;
                end else begin
                    pix_valid = 1'b1;
                    if (cx_r == w_r - 8'd1) begin
                        cx_n = '0;
                        cy_n = cy_r + 7'd1;
                    end else begin
                        cx_n = cx_r + 8'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase

        // Unwrapped sums so pixels past the right/bottom edge are clipped
        // rather than wrapping onto the opposite side.
        sum_x = {1'b0, x0_r} + {1'b0, cx_n};
        sum_y = {1'b0, y0_r} + {1'b0, cy_n};
        if (pix_valid && sum_x < SW && sum_y < SH) begin
            plot_n   = 1'b1;
            x_n      = sum_x[7:0];
            y_n      = sum_y[6:0];
            colour_n = col_r;
        end

        busy_n = (state_n != IDLE);
    end

    assign bus.grant  = grant_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
    assign bus.x      = x_r;
    assign bus.y      = y_r;
    assign bus.colour = colour_r;
    assign bus.plot   = plot_r;
endmodule

// File: doc/pong_draw_scheduler.md
Name: pong_draw_scheduler

Overview:
- Shares the single pixel-write port of the 160x120, 3-bit-colour VGA adapter among several rectangle-drawing requesters: screen clear, left paddle, right paddle and ball.
- Each requester asks for one filled rectangle.
- The scheduler grants one requester at a time and scans the rectangle pixel by pixel.
- It drives the adapter's x, y, colour and plot inputs directly.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest fixed priority.
- SCREEN_W, 160, horizontal resolution; pixels with x >= SCREEN_W are clipped.
- SCREEN_H, 120, vertical resolution; pixels with y >= SCREEN_H are clipped.

Ports:
- clock  input  1  system clock (CLOCK_50 domain).
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester draw request; level, held until done.
- req_x  input  8*NUM_REQ  rectangle left x, requester i at bits [8i+7:8i].
- req_y  input  7*NUM_REQ  rectangle top y, requester i at bits [7i+6:7i].
- req_w  input  8*NUM_REQ  rectangle width in pixels.
- req_h  input  7*NUM_REQ  rectangle height in pixels.
- req_colour  input  3*NUM_REQ  fill colour.
- grant  output  NUM_REQ  one-hot; high for the whole job of the granted requester.
- done  output  NUM_REQ  one-cycle pulse when that requester's rectangle is finished.
- busy  output  1  high in any state other than IDLE.
- x  output  8  pixel x to the adapter.
- y  output  7  pixel y to the adapter.
- colour  output  3  pixel colour to the adapter.
- plot  output  1  pixel write enable to the adapter.

Behaviour:
- Reset values: grant=0, done=0, busy=0, x=0, y=0, colour=0, plot=0; state=IDLE; round-robin pointer=0.
- Reset mid-DRAW aborts the job immediately. No done pulse is issued and no further pixels are written.
- All outputs are registered.
- States:
  - IDLE to LATCH when any req bit is high. The arbiter selects a winner, grant[i] rises at that edge, and the rectangle fields are latched into internal registers.
  - LATCH to DRAW when w!=0 and h!=0; otherwise LATCH to DONE (zero-area job, no plot).
  - DRAW scans x inner, y outer. Counters cx run 0..w-1 and cy run 0..h-1, one pixel per cycle. Output x=x0+cx (9-bit sum) and y=y0+cy (8-bit sum).
  - DRAW: plot=1 only when the sum is < SCREEN_W and < SCREEN_H. Off-screen pixels still consume a cycle, with plot=0. Sums are never wrapped.
  - DRAW to DONE on the cycle after pixel (w-1, h-1) is presented.
  - DONE: done[i]=1 and grant[i]=1 for one cycle, plot=0, then DONE to IDLE.
- Timing: req seen in IDLE at edge 0 gives grant at edge 1. The first pixel is presented after edge 2 and the last after edge w*h+1. done is high during the cycle after edge w*h+2.
- Total occupancy is w*h+3 cycles; IDLE lasts a minimum of one cycle between jobs.
- Request rules:
  - Field changes and req deassertion after the grant edge are ignored for the current job.
  - A req dropped before it is granted is simply not served.
  - A req still high after its done pulse is treated as a new request.
- Simultaneous requests are resolved by the arbiter only in IDLE. Losers wait with grant low.
- colour is held constant for the job; x, y and colour keep their last values when plot=0.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The search starts at index (last_granted+1) mod NUM_REQ; the pointer updates on each grant and is 0 after reset.
- Not defined: fixed priority, lowest index wins. The pointer logic is absent.

Test Plan:
- Single draw: req[1]=1, x0=10, y0=20, w=3, h=2, colour=3'b100 -> grant[1] rises next edge. Exactly 6 plot pulses in order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with colour 4. Then one done[1] pulse; busy low afterwards.
- Clipping: req[3] with x0=158, y0=119, w=4, h=2 -> 8 DRAW cycles. plot=1 only for (158,119) and (159,119); done[3] after 8 DRAW cycles.
- Zero area: req[2] with w=0, h=5 -> grant, then done[2] two edges later; plot never high.
- Contention: req[0] and req[2] raised in the same cycle -> req[0] served first and req[2] granted after an IDLE cycle. With ROUND_ROBIN_EN and req[0] held continuously, req[0] and req[2] alternate grants.
- Reset mid-operation: assert reset during cycle 5 of a 160x120 clear (w=160, h=120) -> plot, grant and busy drop to 0 asynchronously and no done pulse occurs. After release, a new req[1] is served normally.
- Field change ignored: change req_x[1] from 10 to 50 after the grant edge -> every pixel of the job uses x0=10.
